stage_ex_divider: RTL and testbench

Parametrised iterative integer divider for the EX stage, producing one quotient bit per cycle. It serves DIV/DIVU (signed/unsigned) and drives ex_stall_request while it is running. It writes its quotient and remainder to the LO/HI write paths through the existing EX→MEM latch. It generalises the fixed single-cycle EX arithmetic with WIDTH, a signed mode, cancel/flush and divide-by-zero detection.

---
 rtl/cpu_defines.sv | 19 +
 rtl/divider_step.sv | 24 ++
 rtl/stage_ex_divider.sv | 152 +++++++++++++++
 tb/tb_stage_ex_divider.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defines.sv
// Shared EX-stage definitions: divider state encoding, default datapath width
// and the LO/HI destination selectors used when stage_ex writes results.
package cpu_defines;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;
  localparam int unsigned DIV_COUNT_BITS_DEFAULT = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef enum logic {
    DEST_LO = 1'b0,
    DEST_HI = 1'b1
  } hilo_dest_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference when it is non-negative.
module divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_i < divisor_i always holds, so shifted < 2*divisor and fits WIDTH+1 bits
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {1'b0, divisor_i};
    q_bit_o = ~trial[WIDTH];
    rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/stage_ex_divider.sv
// Iterative signed/unsigned divider for the EX stage: one quotient bit per
// cycle, cancel/flush support and divide-by-zero detection.
module stage_ex_divider
  import cpu_defines::*;
#(
  parameter int unsigned WIDTH      = DIV_WIDTH_DEFAULT,
  parameter int unsigned COUNT_BITS = DIV_COUNT_BITS_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic             divide_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e            state_q, state_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]      dvd_q, dvd_d;
  logic [WIDTH-1:0]      dvs_q, dvs_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic [WIDTH-1:0]      quotient_q, quotient_d;
  logic [WIDTH-1:0]      remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;

  logic [WIDTH-1:0]      step_rem;
  logic                  step_q;
  logic [WIDTH-1:0]      dvd_mag;
  logic [WIDTH-1:0]      dvs_mag;
  logic [WIDTH-1:0]      q_mag;
  logic                  accept;

  // dvd_q doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom
  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = 1'b0;
    ready_d     = 1'b0;

    accept  = start & ~cancel;
    dvd_mag = (signed_mode && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag = (signed_mode && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
    q_mag   = {dvd_q[WIDTH-2:0], step_q};

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (accept) begin
          if (divisor == '0) begin
            state_d     = DIV_DONE;
            ready_d     = 1'b1;
            quotient_d  = '0;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = DIV_RUN;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
            count_d = '0;
            rem_d   = '0;
            dvd_d   = dvd_mag;
            dvs_d   = dvs_mag;
            q_neg_d = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = signed_mode & dividend[WIDTH-1];
          end
        end
      end
      DIV_RUN: begin
        if (cancel) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d   = step_rem;
          dvd_d   = q_mag;
          count_d = count_q + COUNT_BITS'(1);
          if (count_q == COUNT_BITS'(WIDTH - 1)) begin
            state_d     = DIV_DONE;
            ready_d     = 1'b1;
            quotient_d  = q_neg_q ? (~q_mag + WIDTH'(1)) : q_mag;
            remainder_d = r_neg_q ? (~step_rem + WIDTH'(1)) : step_rem;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign busy           = busy_q;
  assign ready          = ready_q;
  assign divide_by_zero = dbz_q;
  assign quotient       = quotient_q;
  assign remainder      = remainder_q;

endmodule

// File: tb/tb_stage_ex_divider.sv
// Self-checking bench for stage_ex_divider: arithmetic reference model compared
// every cycle, plus directed operations with hand-computed results and latencies.
module tb_stage_ex_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         sm = 1'b0;
  logic         cancel = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, ready, dz;
  logic [W-1:0] q, r;

  int n_checks = 0;
  int n_fail   = 0;

  stage_ex_divider #(.WIDTH(W), .COUNT_BITS(6)) dut (
    .clock          (clk),
    .reset          (rst_n),
    .start          (start),
    .signed_mode    (sm),
    .cancel         (cancel),
    .dividend       (a),
    .divisor        (b),
    .busy           (busy),
    .ready          (ready),
    .divide_by_zero (dz),
    .quotient       (q),
    .remainder      (r)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain 64-bit arithmetic (truncating division)
  function automatic logic [63:0] divref(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, qq, rr;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    qq = sx / sy;
    rr = sx % sy;
    return {W'(qq), W'(rr)};
  endfunction

  // Transaction-level model: cycles of work left, then a one-cycle ready
  int           m_left;
  logic         m_ready, m_dz;
  logic [W-1:0] m_q, m_r, p_q, p_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_ready <= 1'b0;
      m_dz    <= 1'b0;
      m_q     <= '0;
      m_r     <= '0;
    end else if (cancel) begin
      m_left  <= 0;
      m_ready <= 1'b0;
    end else if (m_left > 0) begin
      m_left  <= m_left - 1;
      m_ready <= (m_left == 1);
      if (m_left == 1) begin
        m_q <= p_q;
        m_r <= p_r;
      end
    end else if (start) begin
      if (b == '0) begin
        m_ready <= 1'b1;
        m_q     <= '0;
        m_r     <= a;
        m_dz    <= 1'b1;
      end else begin
        m_left  <= int'(W);
        m_ready <= 1'b0;
        m_dz    <= 1'b0;
        {p_q, p_r} <= divref(sm, a, b);
      end
    end else begin
      m_ready <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_busy", 64'(busy), 64'(m_left != 0));
      check("cyc_ready", 64'(ready), 64'(m_ready));
      check("cyc_dbz", 64'(dz), 64'(m_dz));
      check("cyc_quotient", 64'(q), 64'(m_q));
      check("cyc_remainder", 64'(r), 64'(m_r));
    end
  end

  // Issue at the current negedge (cycle c0) and wait for ready with a bound
  task automatic do_op(input string name, input logic s, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int exp_lat,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int lat;
    start = 1'b1;
    sm    = s;
    a     = x;
    b     = y;
    lat   = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (ready) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_quotient"}, 64'(q), 64'(eq));
    check({name, "_remainder"}, 64'(r), 64'(er));
    check({name, "_dbz"}, 64'(dz), 64'(edz));
  endtask

  initial begin
    int seen;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_dbz", 64'(dz), 64'd0);
    check("reset_quotient", 64'(q), 64'd0);
    check("reset_remainder", 64'(r), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    do_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
    @(negedge clk);

    do_op("dbz", 1'b0, 32'h1234, 32'd0, 1, 32'd0, 32'h1234, 1'b1);
    @(negedge clk);
    do_op("u9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0);

    do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0);

    // Cancel during c10, then restart at c12
    @(negedge clk);
    start = 1'b1; sm = 1'b0; a = 32'd50; b = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_ready", 64'(ready), 64'd0);
    check("cancel_hold_q", 64'(q), 64'h8000_0000);
    @(negedge clk);
    do_op("after_cancel", 1'b0, 32'd1000, 32'd3, 33, 32'd333, 32'd1, 1'b0);

    // start together with cancel in IDLE must not launch anything
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; a = 32'd20; b = 32'd4;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("startcancel_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("startcancel_q", 64'(q), 64'd333);

    // Back-to-back: second start issued in the DONE cycle
    do_op("b2b_1", 1'b0, 32'd1000, 32'd7, 33, 32'd142, 32'd6, 1'b0);
    do_op("b2b_2", 1'b1, 32'd77, 32'hFFFF_FFF6, 33, 32'hFFFF_FFF9, 32'd7, 1'b0);

    // Asynchronous reset during c5 of a run
    @(negedge clk);
    start = 1'b1; sm = 1'b0; a = 32'd200; b = 32'd9;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_ready", 64'(ready), 64'd0);
    check("midreset_dbz", 64'(dz), 64'd0);
    check("midreset_quotient", 64'(q), 64'd0);
    check("midreset_remainder", 64'(r), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) seen++;
    end
    check("no_ready_after_reset", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
